// File: rtl/rr_arb_pkg.sv
// Shared widths and types for the 4-way round-robin mux arbiter.
// Imported by the picker and the top.
package rr_arb_pkg;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 4;
   localparam int ID_W   = 2;

   typedef logic [N_REQ-1:0]  vec_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ID_W-1:0]   id_t;

   // Pointer advance; the 2-bit width makes 3 -> 0 wrap for free.
   function automatic id_t id_next(input id_t i);
      return id_t'(i + id_t'(1));
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin search over 4 requesters.
// Finds the first valid requester at or above ptr, mod 4.
module rr_pick_4
   import rr_arb_pkg::*;
(
   input  vec_t in_valid,
   input  id_t  ptr,
   output vec_t grant,
   output id_t  gidx,
   output logic any
);

   id_t idx;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      gidx = '0;
      idx  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = id_t'(ptr + id_t'(k));
         if (in_valid[idx]) begin
            gidx = idx;
         end
      end
   end

   assign any   = |in_valid;
   assign grant = any ? (vec_t'(1) << gidx) : '0;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 arbiter feeding a single-entry output register.
// A new item loads whenever the register is empty or being drained.
module rr_mux_arbiter_4
   import rr_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  in_valid,
   input  logic [DATA_W-1:0] in_data_0,
   input  logic [DATA_W-1:0] in_data_1,
   input  logic [DATA_W-1:0] in_data_2,
   input  logic [DATA_W-1:0] in_data_3,
   output logic [N_REQ-1:0]  in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ID_W-1:0]   out_id,
   input  logic              out_ready
);

   id_t   ptr;
   vec_t  grant;
   id_t   gidx;
   logic  any;
   logic  load_en;
   data_t sel_data;

   rr_pick_4 u_pick (
      .in_valid (in_valid),
      .ptr      (ptr),
      .grant    (grant),
      .gidx     (gidx),
      .any      (any)
   );

   assign load_en  = !out_valid || out_ready;
   assign in_ready = (!rst && load_en) ? grant : '0;

   // Payload select driven only by the grant index.
   always_comb begin
      sel_data = '0;
      unique case (gidx)
         2'd0: sel_data = in_data_0;
         2'd1: sel_data = in_data_1;
         2'd2: sel_data = in_data_2;
         2'd3: sel_data = in_data_3;
      endcase
   end

   // Output register and pointer; hold while stalled downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= gidx;
            ptr       <= id_next(gidx);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rr_mux_arbiter_4.md
RR_MUX_ARBITER_4 -- requirements
Module: rr_mux_arbiter_4

Interface
REQ-001 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 Port rst  input  1  reset, synchronous, active-high.
REQ-003 Port in_valid  input  4  bit i = requester i offers in_data_i this cycle.
REQ-004 Ports in_data_0..in_data_3  input  4 each  requester payloads.
REQ-005 Port in_ready  output  4  bit i = requester i's payload accepted this cycle (one-hot or zero).
REQ-006 Port out_valid  output  1  out_data/out_id hold a valid item.
REQ-007 Port out_data  output  4  selected payload, registered.
REQ-008 Port out_id  output  2  index of the requester that supplied out_data.
REQ-009 Port out_ready  input  1  downstream accepts the item when out_valid and out_ready are both 1.

Function
REQ-010 Output stage SHALL be a single register (out_valid, out_data, out_id); load_en = !out_valid || out_ready.
REQ-011 Grant SHALL be combinational: when load_en = 1 and in_valid != 0, exactly one in_ready bit = 1, for the first set in_valid bit searching upward mod 4 from ptr; else in_ready = 0.
REQ-012 in_ready SHALL NOT depend on in_data; it MAY depend on in_valid, out_valid, out_ready, ptr.
REQ-013 On a cycle with in_ready[g] = 1: next out_data = in_data_g, out_id = g, out_valid = 1, ptr = (g+1) mod 4.
REQ-014 On a cycle with load_en = 1 and in_valid = 0: next out_valid = 0; out_data, out_id, ptr unchanged.
REQ-015 On a cycle with load_en = 0 (out_valid = 1, out_ready = 0): out_valid, out_data, out_id, ptr all hold; in_ready = 0.
REQ-016 Latency in_valid&in_ready -> out_valid SHALL be exactly 1 cycle; sustained throughput 1 item/cycle while out_ready = 1.
REQ-017 Simultaneous pop and push (out_valid & out_ready & granted request) SHALL replace the item with no bubble.
REQ-018 Fairness: with all 4 in_valid held high and out_ready = 1, out_id SHALL cycle ptr, ptr+1, ptr+2, ptr+3 and repeat; no requester waits more than 3 grants.
REQ-019 ptr SHALL wrap 3 -> 0; a single active requester SHALL be granted every loadable cycle regardless of ptr.
REQ-020 Requesters SHALL hold in_valid and in_data stable until in_ready; the block need not tolerate withdrawn requests, but a dropped in_valid SHALL simply be skipped by the search.

Reset
REQ-021 While rst = 1 at posedge clk: out_valid = 0, out_data = 0, out_id = 0, ptr = 0.
REQ-022 While rst = 1, in_ready SHALL be 0 (no grants consumed during reset).
REQ-023 Reset asserted mid-transfer SHALL discard the held output item; first grant after reset searches from requester 0.

Structure
REQ-024 Package rr_arb_pkg SHALL hold N_REQ = 4, DATA_W = 4, ID_W = 2.
REQ-025 Sub-module rr_pick_4 (combinational: in_valid, ptr -> one-hot grant, grant index, any) SHALL implement the round-robin search; the data select SHALL use a 4:1 multiplexer indexed by the grant index.
REQ-026 Only ptr and the output register are state; no other storage.

Verification
REQ-027 Reset then in_valid = 4'b0001, in_data_0 = 4'ha, out_ready = 1 -> in_ready = 4'b0001 same cycle; next cycle out_valid = 1, out_data = a, out_id = 0.
REQ-028 After reset, in_valid = 4'b1111, data a,b,c,d, out_ready = 1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3, out_data a,b,c,d,a,b,c,d.
REQ-029 out_valid = 1 with out_id = 1, out_ready = 0 for 3 cycles while in_valid = 4'b1111 -> in_ready = 0, outputs unchanged; then out_ready = 1 -> grant to requester 2 that cycle.
REQ-030 ptr = 3 (last grant 2), in_valid = 4'b0011 -> grant requester 0 (wrap), then requester 1 next cycle.
REQ-031 in_valid = 0, out_ready = 1 while out_valid = 1 -> next cycle out_valid = 0, out_data unchanged.
REQ-032 rst = 1 for one cycle while out_valid = 1 and in_valid = 4'b0100 -> in_ready = 0 that cycle; after reset out_valid = 0, then grant requester 2 with out_id = 2.
